// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// over a shared ALU and memory port, with memory handshake timeout and sticky error flags.
module multicycle_control #(
    parameter int MEM_HANDSHAKE  = 1,
    parameter int TIMEOUT_CYCLES = 15,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    input  logic             err_clr,
    output logic             pcwrite,
    output logic             irwrite,
    output logic             iord,
    output logic             memread,
    output logic             memwrite,
    output logic             memtoreg,
    output logic             regdest,
    output logic             regwrite,
    output logic             alusrca,
    output logic [1:0]       alusrcb,
    output logic [1:0]       aluop,
    output logic [1:0]       pcsrc,
    output logic [3:0]       state,
    output logic             illegal_op,
    output logic             mem_err,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0]  OP_RTYPE = 6'b000000;
    localparam logic [5:0]  OP_LW    = 6'b100011;
    localparam logic [5:0]  OP_SW    = 6'b101011;
    localparam logic [5:0]  OP_ADDI  = 6'b001000;
    localparam logic [5:0]  OP_BEQ   = 6'b000100;
    localparam logic [5:0]  OP_J     = 6'b000010;
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t           state_q, state_d;
    logic [15:0]      wait_q, wait_d;
    logic             illegal_q, illegal_d;
    logic             mem_err_q, mem_err_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    logic ready;
    logic timeout;
    logic wait_inc;
    logic timed_out;
    logic illegal_set;
    logic retire;

    assign ready   = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;
    assign timeout = (TIMEOUT_CYCLES > 0) && !ready && (wait_q == WAIT_LAST);

    always_comb begin
        pcwrite     = 1'b0;
        irwrite     = 1'b0;
        iord        = 1'b0;
        memread     = 1'b0;
        memwrite    = 1'b0;
        memtoreg    = 1'b0;
        regdest     = 1'b0;
        regwrite    = 1'b0;
        alusrca     = 1'b0;
        alusrcb     = 2'b00;
        aluop       = 2'b00;
        pcsrc       = 2'b00;
        state_d     = state_q;
        wait_inc    = 1'b0;
        timed_out   = 1'b0;
        illegal_set = 1'b0;
        retire      = 1'b0;

        case (state_q)
            S_FETCH: begin
                memread = 1'b1;
                alusrcb = 2'b01;
                if (ready) begin
                    irwrite = 1'b1;
                    pcwrite = 1'b1;
                    state_d = S_DECODE;
                end else if (timeout) begin
                    timed_out = 1'b1;
                end else begin
                    wait_inc = 1'b1;
                end
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        illegal_set = 1'b1;
                        state_d     = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                memread = 1'b1;
                iord    = 1'b1;
                if (ready) begin
                    state_d = S_MEMWB;
                end else if (timeout) begin
                    timed_out = 1'b1;
                    state_d   = S_FETCH;
                end else begin
                    wait_inc = 1'b1;
                end
            end
            S_MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEMWR: begin
                memwrite = 1'b1;
                iord     = 1'b1;
                if (ready) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else if (timeout) begin
                    timed_out = 1'b1;
                    state_d   = S_FETCH;
                end else begin
                    wait_inc = 1'b1;
                end
            end
            S_EXEC: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                regwrite = 1'b1;
                regdest  = 1'b1;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                alusrca = 1'b1;
                aluop   = 2'b01;
                pcsrc   = 2'b01;
                pcwrite = zero;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
                regwrite = 1'b1;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_JUMP: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        // A timeout in FETCH does not change state, so it must restart the wait count explicitly
        if (state_d != state_q || timed_out) begin
            wait_d = 16'd0;
        end else if (wait_inc) begin
            wait_d = wait_q + 16'd1;
        end else begin
            wait_d = wait_q;
        end

        illegal_d = illegal_set | (illegal_q & ~err_clr);
        mem_err_d = timed_out | (mem_err_q & ~err_clr);
        retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            wait_q    <= 16'd0;
            illegal_q <= 1'b0;
            mem_err_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            mem_err_q <= mem_err_d;
            retired_q <= retired_d;
        end
    end

    assign state      = state_q;
    assign illegal_op = illegal_q;
    assign mem_err    = mem_err_q;
    assign retired    = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control (4-cycle timeout, 4-bit retired counter).
module tb_multicycle_control;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       err_clr;
    logic       pcwrite, irwrite, iord, memread, memwrite, memtoreg;
    logic       regdest, regwrite, alusrca;
    logic [1:0] alusrcb, aluop, pcsrc;
    logic [3:0] state;
    logic       illegal_op, mem_err;
    logic [3:0] retired;

    int pass_cnt  = 0;
    int total_cnt = 0;

    multicycle_control #(
        .MEM_HANDSHAKE (1),
        .TIMEOUT_CYCLES(4),
        .CNT_W         (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .opcode    (opcode),
        .zero      (zero),
        .mem_ready (mem_ready),
        .err_clr   (err_clr),
        .pcwrite   (pcwrite),
        .irwrite   (irwrite),
        .iord      (iord),
        .memread   (memread),
        .memwrite  (memwrite),
        .memtoreg  (memtoreg),
        .regdest   (regdest),
        .regwrite  (regwrite),
        .alusrca   (alusrca),
        .alusrcb   (alusrcb),
        .aluop     (aluop),
        .pcsrc     (pcsrc),
        .state     (state),
        .illegal_op(illegal_op),
        .mem_err   (mem_err),
        .retired   (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; opcode = 6'b0; zero = 1'b0; mem_ready = 1'b1; err_clr = 1'b0;
        #2;
        total_cnt++;
        if (state !== 4'd0) $display("FAIL reset_state: got %0d expected 0", state); else pass_cnt++;
        total_cnt++;
        if (retired !== 4'd0) $display("FAIL reset_retired: got %0d expected 0", retired); else pass_cnt++;
        total_cnt++;
        if ({illegal_op, mem_err} !== 2'b00)
            $display("FAIL reset_flags: got %b expected 00", {illegal_op, mem_err});
        else pass_cnt++;
        #10;
        rst_n = 1'b1;
    endtask

    task automatic test_rtype();
        int exp_s [5] = '{0, 1, 6, 7, 0};
        opcode = 6'b000000; mem_ready = 1'b1;
        total_cnt++;
        if (irwrite !== 1'b1) $display("FAIL rtype_irwrite: got %b expected 1", irwrite); else pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            total_cnt++;
            if (state !== 4'(exp_s[i]))
                $display("FAIL rtype_state[%0d]: got %0d expected %0d", i, state, exp_s[i]);
            else pass_cnt++;
            total_cnt++;
            if ({regwrite, regdest} !== ((exp_s[i] == 7) ? 2'b11 : 2'b00))
                $display("FAIL rtype_wb[%0d]: got %b expected %b", i, {regwrite, regdest},
                         (exp_s[i] == 7) ? 2'b11 : 2'b00);
            else pass_cnt++;
        end
        total_cnt++;
        if (retired !== 4'd1) $display("FAIL rtype_retired: got %0d expected 1", retired); else pass_cnt++;
    endtask

    task automatic test_lw_wait();
        int   exp_s [9] = '{0, 1, 2, 3, 3, 3, 3, 4, 0};
        logic rdy   [9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        opcode = 6'b100011;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) tick();
            mem_ready = rdy[i];
            #1;
            total_cnt++;
            if (state !== 4'(exp_s[i]))
                $display("FAIL lw_state[%0d]: got %0d expected %0d", i, state, exp_s[i]);
            else pass_cnt++;
            total_cnt++;
            if (memtoreg !== (exp_s[i] == 4))
                $display("FAIL lw_memtoreg[%0d]: got %b expected %b", i, memtoreg, exp_s[i] == 4);
            else pass_cnt++;
        end
        total_cnt++;
        if (retired !== 4'd2) $display("FAIL lw_retired: got %0d expected 2", retired); else pass_cnt++;
    endtask

    task automatic test_beq();
        for (int z = 1; z >= 0; z--) begin
            opcode = 6'b000100; zero = z[0]; mem_ready = 1'b1;
            tick(); tick();
            total_cnt++;
            if (state !== 4'd8) $display("FAIL beq_state z=%0d: got %0d expected 8", z, state); else pass_cnt++;
            total_cnt++;
            if ({pcwrite, pcsrc} !== {z[0], 2'b01})
                $display("FAIL beq_pc z=%0d: got %b expected %b", z, {pcwrite, pcsrc}, {z[0], 2'b01});
            else pass_cnt++;
            tick();
            total_cnt++;
            if (state !== 4'd0) $display("FAIL beq_return z=%0d: got %0d expected 0", z, state); else pass_cnt++;
        end
        total_cnt++;
        if (retired !== 4'd4) $display("FAIL beq_retired: got %0d expected 4", retired); else pass_cnt++;
    endtask

    task automatic test_illegal();
        int exp_j [4] = '{0, 1, 11, 0};
        opcode = 6'b111111; mem_ready = 1'b1;
        tick();
        total_cnt++;
        if (state !== 4'd1) $display("FAIL illegal_decode: got %0d expected 1", state); else pass_cnt++;
        tick();
        total_cnt++;
        if (state !== 4'd0) $display("FAIL illegal_return: got %0d expected 0", state); else pass_cnt++;
        total_cnt++;
        if (illegal_op !== 1'b1) $display("FAIL illegal_set: got %b expected 1", illegal_op); else pass_cnt++;
        total_cnt++;
        if (retired !== 4'd4) $display("FAIL illegal_retired: got %0d expected 4", retired); else pass_cnt++;
        opcode = 6'b000010;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            err_clr = (i == 1);
            total_cnt++;
            if (state !== 4'(exp_j[i]))
                $display("FAIL jump_state[%0d]: got %0d expected %0d", i, state, exp_j[i]);
            else pass_cnt++;
            total_cnt++;
            if (illegal_op !== (i < 2))
                $display("FAIL illegal_sticky[%0d]: got %b expected %b", i, illegal_op, i < 2);
            else pass_cnt++;
        end
        err_clr = 1'b0;
        total_cnt++;
        if (retired !== 4'd5) $display("FAIL jump_retired: got %0d expected 5", retired); else pass_cnt++;
    endtask

    task automatic test_sw_timeout();
        int   exp_s [8] = '{0, 1, 2, 5, 5, 5, 5, 0};
        logic rdy   [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        opcode = 6'b101011;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) tick();
            mem_ready = rdy[i];
            #1;
            total_cnt++;
            if (state !== 4'(exp_s[i]))
                $display("FAIL sw_to_state[%0d]: got %0d expected %0d", i, state, exp_s[i]);
            else pass_cnt++;
            total_cnt++;
            if (memwrite !== (exp_s[i] == 5))
                $display("FAIL sw_to_memwrite[%0d]: got %b expected %b", i, memwrite, exp_s[i] == 5);
            else pass_cnt++;
        end
        total_cnt++;
        if (mem_err !== 1'b1) $display("FAIL sw_to_mem_err: got %b expected 1", mem_err); else pass_cnt++;
        total_cnt++;
        if (retired !== 4'd5) $display("FAIL sw_to_retired: got %0d expected 5", retired); else pass_cnt++;
    endtask

    task automatic test_ready_on_timeout_cycle();
        int   exp_s [8] = '{0, 1, 2, 5, 5, 5, 5, 0};
        logic rdy   [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        opcode = 6'b101011;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) tick();
            mem_ready = rdy[i];
            err_clr   = (i == 0);
            #1;
            total_cnt++;
            if (state !== 4'(exp_s[i]))
                $display("FAIL sw_late_state[%0d]: got %0d expected %0d", i, state, exp_s[i]);
            else pass_cnt++;
        end
        total_cnt++;
        if (mem_err !== 1'b0) $display("FAIL sw_late_mem_err: got %b expected 0", mem_err); else pass_cnt++;
        total_cnt++;
        if (retired !== 4'd6) $display("FAIL sw_late_retired: got %0d expected 6", retired); else pass_cnt++;
    endtask

    task automatic test_wrap_and_reset();
        logic [3:0] exp_ret = 4'd6;
        mem_ready = 1'b1;
        for (int k = 0; k < 11; k++) begin
            opcode = k[0] ? 6'b000010 : 6'b000000;
            for (int c = 0; c < (k[0] ? 3 : 4); c++) tick();
            exp_ret = exp_ret + 4'd1;
            total_cnt++;
            if ({state, retired} !== {4'd0, exp_ret})
                $display("FAIL wrap[%0d]: got state %0d retired %0d expected state 0 retired %0d",
                         k, state, retired, exp_ret);
            else pass_cnt++;
        end
        opcode = 6'b000000;
        tick(); tick();
        total_cnt++;
        if (state !== 4'd6) $display("FAIL pre_reset_state: got %0d expected 6", state); else pass_cnt++;
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({state, retired, regwrite} !== {4'd0, 4'd0, 1'b0})
            $display("FAIL async_reset: got state %0d retired %0d regwrite %b expected 0 0 0",
                     state, retired, regwrite);
        else pass_cnt++;
        #10;
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_wait();
        test_beq();
        test_illegal();
        test_sw_timeout();
        test_ready_on_timeout_cycle();
        test_wrap_and_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle MIPS control FSM; successor to the single-cycle opcode decoder.
- Sequences fetch/decode/execute/memory/writeback over several cycles, sharing one ALU and one memory port.
- Supports R-type, addi, lw, sw, beq and j.
- Adds a memory ready handshake with timeout, sticky error flags and a retired-instruction counter.
- Sits between the instruction register (IR) and the datapath muxes and enables.

Parameters:
- MEM_HANDSHAKE, 1, 1 = memory states wait for mem_ready; 0 = memory completes in one cycle and mem_ready is ignored.
- TIMEOUT_CYCLES, 15, maximum number of wait cycles in a memory state before abort; 0 disables the timeout.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  IR[31:26]; stable from DECODE until the return to FETCH
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory access complete this cycle
- err_clr  in  1  clears the sticky error flags
- pcwrite  out  1  PC write enable
- irwrite  out  1  IR write enable
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- memread  out  1  memory read strobe
- memwrite  out  1  memory write strobe
- memtoreg  out  1  writeback source: 1 = MDR
- regdest  out  1  destination register: 1 = rd, 0 = rt
- regwrite  out  1  register file write enable
- alusrca  out  1  ALU A source: 0 = PC, 1 = rs
- alusrcb  out  2  ALU B source: 00 = rt, 01 = 4, 10 = sign-extended imm, 11 = imm<<2
- aluop  out  2  00 = add, 01 = sub, 10 = funct
- pcsrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- state  out  4  current state code
- illegal_op  out  1  sticky: an unknown opcode was decoded
- mem_err  out  1  sticky: a memory timeout occurred
- retired  out  CNT_W  count of completed instructions, wraps

Behaviour:
- Reset (asynchronous): state = FETCH (0); wait counter = 0; retired = 0; illegal_op = 0; mem_err = 0.
- Default value of every control output is 0; each state drives only the listed outputs.
- "ready" means mem_ready when MEM_HANDSHAKE = 1, and constant 1 when MEM_HANDSHAKE = 0.
- FETCH (0):
  - memread = 1, alusrca = 0, alusrcb = 01, aluop = 00, pcsrc = 00.
  - irwrite = pcwrite = ready (combinational, Mealy).
  - On ready: go to DECODE.
- DECODE (1): alusrcb = 11, aluop = 00. Next state by opcode:
  - 100011 (lw) or 101011 (sw) -> MEMADR
  - 000000 (R-type) -> EXEC
  - 001000 (addi) -> ADDIEX
  - 000100 (beq) -> BRANCH
  - 000010 (j) -> JUMP
  - any other opcode -> FETCH, set illegal_op, do not increment retired.
- MEMADR (2): alusrca = 1, alusrcb = 10, aluop = 00. lw -> MEMRD; sw -> MEMWR.
- MEMRD (3): memread = 1, iord = 1. On ready -> MEMWB.
- MEMWB (4): regwrite = 1, memtoreg = 1, regdest = 0. -> FETCH.
- MEMWR (5): memwrite = 1, iord = 1. On ready -> FETCH.
- EXEC (6): alusrca = 1, alusrcb = 00, aluop = 10. -> ALUWB.
- ALUWB (7): regwrite = 1, regdest = 1. -> FETCH.
- BRANCH (8): alusrca = 1, alusrcb = 00, aluop = 01, pcsrc = 01, pcwrite = zero. -> FETCH.
- ADDIEX (9): alusrca = 1, alusrcb = 10, aluop = 00. -> ADDIWB.
- ADDIWB (10): regwrite = 1, regdest = 0. -> FETCH.
- JUMP (11): pcsrc = 10, pcwrite = 1. -> FETCH.
- Codes 12-15 are unreachable; if entered, go to FETCH with all outputs 0.
- Wait counter:
  - Clears on every state change.
  - Increments each cycle spent in FETCH, MEMRD or MEMWR while ready = 0.
  - Timeout: if TIMEOUT_CYCLES > 0 and the counter equals TIMEOUT_CYCLES - 1 with ready = 0, then set mem_err and go to FETCH. No pcwrite, irwrite, regwrite or retire on that cycle.
  - mem_ready arriving on the timeout cycle wins: normal completion, no error.
- retired increments by 1 (wrapping from 2^CNT_W - 1 to 0) on each transition to FETCH from:
  - MEMWB, ALUWB, ADDIWB, BRANCH, JUMP, or
  - MEMWR with ready.
  - Not on illegal-opcode or timeout returns.
- err_clr clears both sticky flags. A new error in the same cycle takes priority, so the flag stays 1.
- Latency with ready = 1 in every wait state:
  - lw: 5 cycles
  - sw, R-type, addi: 4 cycles
  - beq, j: 3 cycles
- rst_n low mid-instruction returns to FETCH immediately; any half-done writeback is discarded.

Test Plan:
- Reset, MEM_HANDSHAKE = 1, mem_ready tied 1, opcode 000000 -> state sequence 0,1,6,7,0; regwrite = regdest = 1 in state 7 only; retired = 1.
- lw with mem_ready low for 3 cycles in MEMRD -> sequence 0,1,2,3,3,3,3,4,0; memtoreg = 1 in state 4; retired += 1.
- beq with zero = 1, then beq with zero = 0 -> pcwrite = 1 in state 8, then pcwrite = 0 in state 8; pcsrc = 01 both times.
- Opcode 111111 -> DECODE then FETCH; illegal_op = 1 and stays 1; retired unchanged; err_clr pulse -> illegal_op = 0.
- TIMEOUT_CYCLES = 4, sw with mem_ready held 0 -> 4 cycles in state 5, then FETCH; mem_err = 1; memwrite drops; retired unchanged.
- CNT_W = 4: run 16 instructions (R-type and j) -> retired wraps 15 -> 0; rst_n low mid-EXEC -> state = 0 and retired = 0 asynchronously.
